// File: rtl/iob_spi_xip_rdbuf_pkg.sv
// Shared definitions for the SPI XIP read buffer.
// Holds the controller state encoding and the address-field width helpers
// used to split a flash byte address into tag / word index / byte offset.
package iob_spi_xip_rdbuf_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2
  } state_t;

  // Word-index width: log2 of the number of words in the line buffer.
  function automatic int unsigned word_idx_w(input int unsigned line_words);
    return $clog2(line_words);
  endfunction

  // Tag width: everything above the word index and the 2-bit byte offset.
  function automatic int unsigned tag_w(input int unsigned flash_addr_w,
                                        input int unsigned line_words);
    return flash_addr_w - 2 - $clog2(line_words);
  endfunction

endpackage

// File: rtl/iob_spi_xip_line_mem.sv
// Line storage for the XIP read buffer: LINE_WORDS x DATA_W.
// Ports:
//   clk_i            clock (rising edge)
//   we_i/waddr_i/wdata_i  synchronous write port
//   raddr_i/rdata_o  asynchronous read port
// Contents are not reset.
module iob_spi_xip_line_mem #(
  parameter int DATA_W     = 32,
  parameter int LINE_WORDS = 4,
  parameter int ADDR_W     = 2
) (
  input  logic              clk_i,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic [ADDR_W-1:0] raddr_i,
  output logic [DATA_W-1:0] rdata_o
);

  logic [DATA_W-1:0] mem [LINE_WORDS];

  always_ff @(posedge clk_i) begin
    if (we_i) mem[waddr_i] <= wdata_i;
  end

  assign rdata_o = mem[raddr_i];

endmodule

// File: rtl/iob_spi_xip_rdbuf.sv
// SPI flash execute-in-place read buffer: a single line buffer in front of a
// word-read SPI flash controller.
// Ports:
//   clk_i, arst_i        clock, asynchronous active-high reset
//   flush_i              invalidates the line buffer
//   iob_avalid_i/iob_addr_i/iob_wstrb_i/iob_ready_o/iob_rvalid_o/iob_rdata_o
//                        CPU side (writes only invalidate the line)
//   fl_valid_o/fl_addr_o/fl_ready_i/fl_rdata_i
//                        word-read requests to the flash controller
// Configuration macro: IOB_SPI_XIP_RDBUF_CWF_EN -- critical word first fill.
module iob_spi_xip_rdbuf
  import iob_spi_xip_rdbuf_pkg::*;
#(
  parameter int DATA_W       = 32,
  parameter int FLASH_ADDR_W = 24,
  parameter int LINE_WORDS   = 4
) (
  input  logic                    clk_i,
  input  logic                    arst_i,
  input  logic                    flush_i,
  input  logic                    iob_avalid_i,
  input  logic [FLASH_ADDR_W-1:0] iob_addr_i,
  input  logic [DATA_W/8-1:0]     iob_wstrb_i,
  output logic                    iob_ready_o,
  output logic                    iob_rvalid_o,
  output logic [DATA_W-1:0]       iob_rdata_o,
  output logic                    fl_valid_o,
  output logic [FLASH_ADDR_W-1:0] fl_addr_o,
  input  logic                    fl_ready_i,
  input  logic [DATA_W-1:0]       fl_rdata_i
);

  localparam int unsigned WORD_IDX_W = word_idx_w(LINE_WORDS);
  localparam int unsigned TAG_W      = tag_w(FLASH_ADDR_W, LINE_WORDS);

  state_t                  state_q, state_d;
  logic                    line_valid_q;
  logic                    fill_flushed_q;
  logic [TAG_W-1:0]        tag_q;
  logic [WORD_IDX_W-1:0]   req_idx_q;
  logic [WORD_IDX_W-1:0]   cnt_q;
  logic [WORD_IDX_W-1:0]   cnt_nxt;
  logic [WORD_IDX_W-1:0]   fill_start;
  logic [WORD_IDX_W-1:0]   miss_start;
  logic [TAG_W-1:0]        addr_tag;
  logic [WORD_IDX_W-1:0]   addr_idx;
  logic                    accept, is_write, hit;
  logic                    fill_beat, fill_last, resp_beat;
  logic [WORD_IDX_W-1:0]   mem_raddr;
  logic [DATA_W-1:0]       mem_rdata;
  logic [DATA_W-1:0]       resp_data;
  logic [FLASH_ADDR_W-1:0] fl_addr_q;
  logic                    rvalid_q;
  logic [DATA_W-1:0]       rdata_q;
  logic                    unused_addr_lsb;

  assign unused_addr_lsb = ^iob_addr_i[1:0];

  assign addr_idx = iob_addr_i[2 +: WORD_IDX_W];
  assign addr_tag = iob_addr_i[FLASH_ADDR_W-1 -: TAG_W];

  assign iob_ready_o = (state_q == IDLE);
  assign fl_valid_o  = (state_q == REQ);
  assign fl_addr_o   = fl_addr_q;
  assign iob_rvalid_o = rvalid_q;
  assign iob_rdata_o  = rdata_q;

  assign accept   = iob_avalid_i & iob_ready_o;
  assign is_write = |iob_wstrb_i;
  // A flush arriving with the request turns it into a miss.
  assign hit      = line_valid_q & ~flush_i & (tag_q == addr_tag);

  assign fill_beat = (state_q == WAIT) & fl_ready_i;
  assign cnt_nxt   = cnt_q + 1'b1;

`ifdef IOB_SPI_XIP_RDBUF_CWF_EN
  assign miss_start = addr_idx;
  assign fill_start = req_idx_q;
  // The requested word is the first one fetched.
  assign resp_beat  = fill_beat & (cnt_q == req_idx_q);
`else
  assign miss_start = '0;
  assign fill_start = '0;
  assign resp_beat  = fill_beat & fill_last;
`endif

  // The counter wraps at LINE_WORDS, so the fill ends on the word just
  // before the one it started from.
  assign fill_last = (cnt_nxt == fill_start);

  // IDLE reads the CPU-addressed word for hits; during a fill the port is
  // free to fetch the requested word for the end-of-fill response.
  assign mem_raddr = (state_q == IDLE) ? addr_idx : req_idx_q;
  assign resp_data = (cnt_q == req_idx_q) ? fl_rdata_i : mem_rdata;

  iob_spi_xip_line_mem #(
    .DATA_W    (DATA_W),
    .LINE_WORDS(LINE_WORDS),
    .ADDR_W    (WORD_IDX_W)
  ) u_line_mem (
    .clk_i  (clk_i),
    .we_i   (fill_beat),
    .waddr_i(cnt_q),
    .wdata_i(fl_rdata_i),
    .raddr_i(mem_raddr),
    .rdata_o(mem_rdata)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (accept && !is_write && !hit) state_d = REQ;
      REQ:  state_d = WAIT;
      WAIT: if (fl_ready_i) state_d = fill_last ? IDLE : REQ;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      state_q        <= IDLE;
      line_valid_q   <= 1'b0;
      fill_flushed_q <= 1'b0;
      tag_q          <= '0;
      req_idx_q      <= '0;
      cnt_q          <= '0;
      fl_addr_q      <= '0;
      rvalid_q       <= 1'b0;
      rdata_q        <= '0;
    end else begin
      state_q  <= state_d;
      rvalid_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (accept) begin
            if (is_write) begin
              line_valid_q <= 1'b0;
            end else if (hit) begin
              rvalid_q <= 1'b1;
              rdata_q  <= mem_rdata;
            end else begin
              tag_q          <= addr_tag;
              req_idx_q      <= addr_idx;
              cnt_q          <= miss_start;
              line_valid_q   <= 1'b0;
              fill_flushed_q <= 1'b0;
              fl_addr_q      <= {addr_tag, miss_start, 2'b00};
            end
          end
        end
        WAIT: begin
          if (fl_ready_i) begin
            if (resp_beat) begin
              rvalid_q <= 1'b1;
              rdata_q  <= resp_data;
            end
            if (fill_last) begin
              line_valid_q <= ~(fill_flushed_q | flush_i);
            end else begin
              cnt_q     <= cnt_nxt;
              fl_addr_q <= {tag_q, cnt_nxt, 2'b00};
            end
          end
        end
        default: ;
      endcase
      // Flush overrides any valid update above; a flush seen mid-fill is
      // remembered so the completing fill leaves the line invalid.
      if (flush_i) begin
        line_valid_q <= 1'b0;
        if (state_q != IDLE) fill_flushed_q <= 1'b1;
      end
    end
  end

endmodule
